// File: rtl/pipeline_reg_pkg.sv
// Shared pipeline-register types for the fetch/decode boundary and the
// redirect target mask applied to JALR targets.
package pipeline_reg_pkg;

  localparam int unsigned PIPE_XLEN = 32;

  typedef struct packed {
    logic [PIPE_XLEN-1:0] pc;
    logic [PIPE_XLEN-1:0] ir;
  } if_id_reg_t;

  localparam logic [PIPE_XLEN-1:0] REDIRECT_MASK = 32'hffff_fffe;

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of if_id_reg_t with push/pop/flush and an
// occupancy count; flush overrides push and pop.
module fetch_fifo
  import pipeline_reg_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  if_id_reg_t             i_data,
  output if_id_reg_t             o_data,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  if_id_reg_t       r_mem [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [AW:0]      r_count;

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_tail] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + AW'(1);
      if (i_pop)  r_head <= r_head + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: one-outstanding imem requester feeding a fetch queue,
// with redirect/flush and stale-response discard. Optional IF_BYPASS_EN.
module if_fetch_queue
  import pipeline_reg_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h4000_0060
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_read,
  output logic [XLEN-1:0] imem_address,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_resp,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_mask,
  output logic            if_valid,
  input  logic            if_ready,
  output if_id_reg_t      if_reg
);

  localparam int unsigned   CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_t    r_state, w_state_nx;
  logic [XLEN-1:0] r_fetch_pc, w_fetch_pc_nx;
  logic [XLEN-1:0] r_req_pc, w_req_pc_nx;
  logic            r_pending, w_pending_nx;

  logic [CW-1:0]   w_count;
  if_id_reg_t      w_head;
  if_id_reg_t      w_resp_entry;
  logic            w_q_valid;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;

  assign w_resp_entry = '{pc: r_req_pc, ir: imem_rdata};

`ifdef IF_BYPASS_EN
  assign w_bypass = (w_count == '0) && r_pending && imem_resp && !redirect && (r_state == FETCH);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_q_valid = (w_count != '0) && !redirect;
  assign if_valid  = w_q_valid || w_bypass;
  assign if_reg    = w_q_valid ? w_head : w_resp_entry;

  // A bypassed response that decode takes this cycle never enters the queue.
  assign w_pop  = w_q_valid && if_ready;
  assign w_push = r_pending && imem_resp && (r_state == FETCH) && !redirect
                  && !(w_bypass && if_ready);

  assign imem_read    = r_pending;
  assign imem_address = r_req_pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_data  (w_resp_entry),
    .o_data  (w_head),
    .o_count (w_count)
  );

  always_comb begin
    w_state_nx    = r_state;
    w_fetch_pc_nx = r_fetch_pc;
    w_req_pc_nx   = r_req_pc;
    w_pending_nx  = r_pending;
    unique case (r_state)
      FETCH: begin
        if (r_pending && imem_resp) begin
          w_pending_nx = 1'b0;
          if (!redirect) w_fetch_pc_nx = r_fetch_pc + XLEN'(4);
        end else if (r_pending && redirect) begin
          w_state_nx = DISCARD;
        end else if (!r_pending && !redirect && ((w_count < FULL) || w_pop)) begin
          w_pending_nx = 1'b1;
          w_req_pc_nx  = r_fetch_pc;
        end
      end
      DISCARD: begin
        if (imem_resp) begin
          w_pending_nx = 1'b0;
          w_state_nx   = FETCH;
        end
      end
      default: w_state_nx = FETCH;
    endcase
    if (redirect) begin
      w_fetch_pc_nx = redirect_mask ? (redirect_pc & REDIRECT_MASK[XLEN-1:0]) : redirect_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FETCH;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_pending  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_fetch_pc <= w_fetch_pc_nx;
      r_req_pc   <= w_req_pc_nx;
      r_pending  <= w_pending_nx;
    end
  end

endmodule
